rr_mux8: RTL

//  8-to-1 round-robin stream multiplexer: the collecting end of the 1-to-8 demux path.

---
 rtl/rr_mux8_if.sv | 33 +++
 rtl/rr_mux8.sv | 80 ++++++++
 2 files changed

// File: rtl/rr_mux8_if.sv
// rr_mux8 stream bundle: eight request channels in, one tagged stream out.
// slave is the mux side, master is the side feeding and draining it.
interface rr_mux8_if #(
    parameter int DATA_W = 8
);
    logic [7:0]          in_valid;
    logic [8*DATA_W-1:0] in_data;
    logic [7:0]          in_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          out_sel;
    logic                out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready
    );
endinterface

// File: rtl/rr_mux8.sv
// rr_mux8: 8-to-1 round-robin stream mux with one registered output stage.
// Each output word carries its source channel index in out_sel.
module rr_mux8 #(
    parameter int DATA_W = 8
) (
    input logic      clk,
    input logic      rst_n,
    rr_mux8_if.slave bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_sel_q, out_sel_d;
    logic [2:0]        ptr_q, ptr_d;

    logic       load;
    logic       found;
    logic [2:0] gidx;
    logic [2:0] idx;

    // Rotating priority search starting at ptr; the first valid channel wins.
    always_comb begin
        found = 1'b0;
        gidx  = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
    end

    // Accept a word when the stage is empty or is being drained this cycle.
    always_comb begin
        load = (out_valid_q == EMPTY) || bus.out_ready;
        bus.in_ready = 8'h00;
        if (rst_n && load && found) begin
            bus.in_ready[gidx] = 1'b1;
        end
    end

    // Next-state for the output register and the priority pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load && found) begin
            out_valid_d = FULL;
            out_data_d  = bus.in_data[int'(gidx)*DATA_W +: DATA_W];
            out_sel_d   = gidx;
            ptr_d       = gidx + 3'd1;
        end else if (out_valid_q == FULL && bus.out_ready) begin
            out_valid_d = EMPTY;
        end
    end

    // State registers; reset drops any held word and restarts the search at ch0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= 3'd0;
            ptr_q       <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q[0];
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule
